// File: rtl/skid_buffer_pipe.sv
// Two-entry skid buffer: fully registered valid/ready pipeline stage with a main and an overflow register.
// Optional synchronous flush port, enabled by defining SKID_BUF_FLUSH_EN.
module skid_buffer_pipe #(
  parameter int DATA_W   = 8,
  parameter bit DATA_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        count
`ifdef SKID_BUF_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  // Handshake: a beat moves on a side at a rising edge when its valid and ready are
  // both high; valid never waits on ready, and s_ready/m_valid/m_data come straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                m_valid_q, s_ready_q;
  logic [DATA_W-1:0]   main_q, skid_q, main_d;
  logic                main_we, skid_we;
  logic                in_fire, out_fire;

  assign in_fire  = s_valid & s_ready_q;
  assign out_fire = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    main_we = 1'b0;
    skid_we = 1'b0;
    main_d  = s_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_we = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_we = 1'b1;
        end else if (in_fire) begin
          skid_we = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_we = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef SKID_BUF_FLUSH_EN
    // Flush wins over any transfer; the data registers are left untouched.
    if (flush) begin
      state_d = EMPTY;
      main_we = 1'b0;
      skid_we = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      m_valid_q <= (state_d != EMPTY);
      s_ready_q <= (state_d != FULL);
    end
  end

  generate
    if (DATA_RST) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_q <= '0;
          skid_q <= '0;
        end else begin
          if (main_we) main_q <= main_d;
          if (skid_we) skid_q <= s_data;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (main_we) main_q <= main_d;
        if (skid_we) skid_q <= s_data;
      end
    end
  endgenerate

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;
  // State encoding equals occupancy, so count doubles as the visible FSM state.
  assign count   = state_q;

endmodule

// File: tb/tb_skid_buffer_pipe.sv
// Bench for skid_buffer_pipe: directed scenarios plus a randomized stream checked against an
// occupancy-queue reference model and an in-order scoreboard. Flush scenario runs with SKID_BUF_FLUSH_EN.
module tb_skid_buffer_pipe;

  localparam int W = 16;
  localparam int N_BEATS = 10000;
  localparam int CYC_LIMIT = 80000;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   count;
  logic         flush_r;

  int compared;
  int mismatched;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];

  skid_buffer_pipe #(.DATA_W(W), .DATA_RST(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
`ifdef SKID_BUF_FLUSH_EN
    ,
    .flush   (flush_r)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies inputs for one edge and advances the reference model (at most two beats held,
  // beats leave from the front, flush empties it). Starts and ends just after a falling edge.
  task automatic drive(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
    bit in_ok, out_ok;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush_r = fl;
    in_ok  = sv && (model_q.size() < 2);
    out_ok = mr && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (out_ok) void'(model_q.pop_front());
      if (in_ok) model_q.push_back(sd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush_r = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || count !== 2'd0 || m_data !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got mv=%b sr=%b cnt=%0d data=%h, want mv=0 sr=1 cnt=0 data=0",
               m_valid, s_ready, count, m_data);
    end
    rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [W-1:0] vals[3];
    vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b0);
      compared++;
      if (m_valid !== 1'b1 || m_data !== vals[i] || count !== 2'd1 || s_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL stream_beat%0d: got mv=%b data=%h cnt=%0d sr=%b, want mv=1 data=%h cnt=1 sr=1",
                 i, m_valid, m_data, count, s_ready, vals[i]);
      end
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    compared++;
    if (m_valid !== 1'b0 || count !== 2'd0) begin
      mismatched++;
      $display("FAIL stream_drain: got mv=%b cnt=%0d, want mv=0 cnt=0", m_valid, count);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h00A0, 1'b0, 1'b0);
    compared++;
    if (count !== 2'd1 || m_data !== 16'h00A0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_first: got cnt=%0d data=%h sr=%b, want cnt=1 data=00a0 sr=1", count, m_data, s_ready);
    end
    drive(1'b1, 16'h00A1, 1'b0, 1'b0);
    compared++;
    if (count !== 2'd2 || m_data !== 16'h00A0 || s_ready !== 1'b0 || m_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_full: got cnt=%0d data=%h sr=%b mv=%b, want cnt=2 data=00a0 sr=0 mv=1",
               count, m_data, s_ready, m_valid);
    end
    // Offered data while full must be ignored, and the head must stay stable.
    drive(1'b1, 16'h00EE, 1'b0, 1'b0);
    compared++;
    if (count !== 2'd2 || m_data !== 16'h00A0) begin
      mismatched++;
      $display("FAIL bp_hold: got cnt=%0d data=%h, want cnt=2 data=00a0", count, m_data);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    compared++;
    if (count !== 2'd1 || m_data !== 16'h00A1 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_pop1: got cnt=%0d data=%h sr=%b, want cnt=1 data=00a1 sr=1", count, m_data, s_ready);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    compared++;
    if (count !== 2'd0 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_pop2: got cnt=%0d mv=%b, want cnt=0 mv=0", count, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    compared++;
    if (count !== 2'd2) begin
      mismatched++;
      $display("FAIL rstmid_fill: got cnt=%0d, want 2", count);
    end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || count !== 2'd0 || m_data !== '0) begin
      mismatched++;
      $display("FAIL rstmid_async: got mv=%b sr=%b cnt=%0d data=%h, want mv=0 sr=1 cnt=0 data=0",
               m_valid, s_ready, count, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    drive(1'b1, 16'h0033, 1'b0, 1'b0);
    compared++;
    if (count !== 2'd1 || m_data !== 16'h0033 || m_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_accept: got cnt=%0d data=%h mv=%b, want cnt=1 data=0033 mv=1", count, m_data, m_valid);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    compared++;
    if (count !== 2'd0 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_alone: got cnt=%0d mv=%b, want cnt=0 mv=0", count, m_valid);
    end
  endtask

`ifdef SKID_BUF_FLUSH_EN
  task automatic test_flush();
    drive(1'b1, 16'h0044, 1'b0, 1'b0);
    drive(1'b1, 16'h0055, 1'b0, 1'b0);
    drive(1'b1, 16'h0066, 1'b1, 1'b1);
    compared++;
    if (count !== 2'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_empty: got cnt=%0d mv=%b sr=%b, want cnt=0 mv=0 sr=1", count, m_valid, s_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      compared++;
      if (m_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_no_emerge%0d: got mv=%b data=%h, want mv=0", i, m_valid, m_data);
      end
    end
    drive(1'b1, 16'h0077, 1'b0, 1'b0);
    compared++;
    if (m_valid !== 1'b1 || m_data !== 16'h0077 || count !== 2'd1) begin
      mismatched++;
      $display("FAIL flush_after: got mv=%b data=%h cnt=%0d, want mv=1 data=0077 cnt=1", m_valid, m_data, count);
    end
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    int tx, rx, cyc;
    logic sv, mr;
    logic [W-1:0] d, e;
    tx = 0; rx = 0; cyc = 0;
    exp_q.delete();
    while (rx < N_BEATS && cyc < CYC_LIMIT) begin
      sv = (tx < N_BEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
      mr = 1'($urandom_range(0, 1));
      d  = W'(tx);
      compared++;
      if (m_valid !== (model_q.size() > 0) || s_ready !== (model_q.size() < 2) ||
          count !== 2'(model_q.size()) || (model_q.size() > 0 && m_data !== model_q[0])) begin
        mismatched++;
        $display("FAIL rand_state cyc%0d: got mv=%b sr=%b cnt=%0d data=%h, want cnt=%0d head=%h",
                 cyc, m_valid, s_ready, count, m_data, model_q.size(),
                 (model_q.size() > 0) ? model_q[0] : '0);
      end
      if (m_valid === 1'b1 && mr) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rand_extra_beat cyc%0d: got data=%h, want no beat", cyc, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            mismatched++;
            $display("FAIL rand_order cyc%0d: got data=%h, want %h", cyc, m_data, e);
          end
        end
        rx++;
      end
      if (sv && s_ready === 1'b1) begin
        exp_q.push_back(d);
        tx++;
      end
      drive(sv, d, mr, 1'b0);
      cyc++;
    end
    compared++;
    if (rx != N_BEATS || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rand_complete: got rx=%0d left=%0d after %0d cycles, want rx=%0d left=0",
               rx, exp_q.size(), cyc, N_BEATS);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid();
`ifdef SKID_BUF_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/skid_buffer_pipe.md
SKID_BUFFER_PIPE -- requirements
Module: skid_buffer_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal range 1..1024).
REQ-002 SHALL have parameter DATA_RST, default 1; 1 = data registers cleared to zero on reset, 0 = data registers not reset.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_valid  input  1  ingress valid.
REQ-006 SHALL have port s_ready  output  1  ingress ready, driven directly by a flop.
REQ-007 SHALL have port s_data  input  DATA_W  ingress payload.
REQ-008 SHALL have port m_valid  output  1  egress valid, driven directly by a flop.
REQ-009 SHALL have port m_ready  input  1  egress ready.
REQ-010 SHALL have port m_data  output  DATA_W  egress payload, driven directly by the main register.
REQ-011 SHALL have port count  output  2  occupancy (0, 1 or 2 beats held).
REQ-012 SHALL have port flush  input  1  synchronous discard; present only when SKID_BUF_FLUSH_EN is defined.

Function
REQ-013 SHALL hold two registers: main (feeds m_data) and skid (overflow).
REQ-014 SHALL implement states EMPTY (count 0), BUSY (count 1), FULL (count 2).
REQ-015 SHALL assert m_valid in BUSY and FULL only; SHALL assert s_ready in EMPTY and BUSY only.
REQ-016 A beat transfers on ingress when s_valid & s_ready, and on egress when m_valid & m_ready, at the rising edge.
REQ-017 EMPTY: ingress beat -> main <= s_data, go BUSY; otherwise stay.
REQ-018 BUSY: ingress and egress -> main <= s_data, stay BUSY; ingress only -> skid <= s_data, go FULL; egress only -> go EMPTY; neither -> hold.
REQ-019 FULL: egress -> main <= skid, go BUSY; otherwise hold; s_data ignored (s_ready low).
REQ-020 Latency SHALL be one cycle from ingress transfer to m_valid on an empty buffer; sustained throughput SHALL be one beat per cycle with m_ready held high.
REQ-021 SHALL never drop, duplicate or reorder beats; m_data SHALL be stable while m_valid & !m_ready.
REQ-022 s_valid deasserting without a transfer, or s_data changing while s_ready is low, SHALL have no effect.
REQ-023 No combinational path SHALL exist from any input to s_ready, m_valid or m_data.

Reset
REQ-024 On rst_n low, asynchronously: state EMPTY, count 0, m_valid 0, s_ready 1.
REQ-025 With DATA_RST = 1, main and skid SHALL clear to zero (m_data = 0); with DATA_RST = 0 they SHALL keep their value.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; the first edge after release with s_valid high SHALL accept a beat.

Configuration
REQ-027 Macro SKID_BUF_FLUSH_EN defined: flush port exists; flush high at an edge forces EMPTY (m_valid 0, s_ready 1, count 0 next cycle), overriding any transfer in that cycle; the ingress beat offered in that cycle SHALL be discarded; data registers unchanged.
REQ-028 Macro SKID_BUF_FLUSH_EN undefined: no flush port and no flush logic; behaviour is REQ-013..REQ-026 only.

Verification
REQ-029 Reset release, DATA_W=8, m_ready=1, s_valid=1 with data 0x01,0x02,0x03 on consecutive cycles -> m_data 0x01,0x02,0x03 one cycle later, count 1 throughout, s_ready constant 1.
REQ-030 Stream 0xA0,0xA1 with m_ready=0 -> count 1 then 2, s_ready 0 after the second beat; m_ready=1 for 2 cycles -> egress 0xA0 then 0xA1, count 2->1->0.
REQ-031 Random s_valid/m_ready (50% each), 10000 beats of incrementing 16-bit data -> scoreboard sees every beat exactly once, in order.
REQ-032 FULL with 0x11,0x22, assert rst_n low for 1 cycle mid-cycle -> m_valid 0, s_ready 1, count 0, m_data 0x00 (DATA_RST=1) immediately; next beat 0x33 emerges alone.
REQ-033 SKID_BUF_FLUSH_EN defined, FULL with 0x44,0x55, flush=1 and s_valid=1 with 0x66 in the same cycle -> next cycle count 0, m_valid 0, s_ready 1; 0x44, 0x55 and 0x66 never emerge.
